// File: rtl/ro_scan_ctrl_if.sv
// Command and result channel of the ring-oscillator scan controller.
// The host side uses the master modport, the controller the slave modport.
interface ro_scan_ctrl_if #(
    parameter int IDX_W  = 7,
    parameter int GATE_W = 16,
    parameter int CNT_W  = 24
);
    logic              start;
    logic              abort;
    logic [IDX_W-1:0]  first_idx;
    logic [IDX_W-1:0]  last_idx;
    logic [GATE_W-1:0] gate_cycles;
    logic              busy;
    logic              done;
    logic              err;
    logic              res_valid;
    logic              res_ready;
    logic [IDX_W-1:0]  res_idx;
    logic [CNT_W-1:0]  res_count;
    logic              res_sat;

    modport master (
        output start, abort, first_idx, last_idx, gate_cycles, res_ready,
        input  busy, done, err, res_valid, res_idx, res_count, res_sat
    );

    modport slave (
        input  start, abort, first_idx, last_idx, gate_cycles, res_ready,
        output busy, done, err, res_valid, res_idx, res_count, res_sat
    );
endinterface

// File: rtl/ro_scan_ctrl.sv
// Ring-oscillator scan controller: enables one oscillator at a time, lets it settle,
// counts its synchronized rising edges over a gate window and hands the count out.
module ro_scan_ctrl #(
    parameter int NUM_RO     = 100,
    parameter int IDX_W      = 7,
    parameter int GATE_W     = 16,
    parameter int CNT_W      = 24,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_en,
    ro_scan_ctrl_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int               SET_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W:0]   NUM_RO_W    = (IDX_W + 1)'(NUM_RO);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t            state;
    state_t            state_next;

    logic [IDX_W-1:0]  cur_idx;
    logic [IDX_W-1:0]  last_q;
    logic [GATE_W-1:0] gate_q;
    logic [SET_W-1:0]  settle_cnt;
    logic [GATE_W-1:0] gate_cnt;
    logic [1:0]        sync_q;
    logic              edge_hist;
    logic [CNT_W-1:0]  count;
    logic              sat;

    logic [IDX_W-1:0]  res_idx_q;
    logic [CNT_W-1:0]  res_count_q;
    logic              res_sat_q;
    logic              done_q;
    logic              err_q;

    logic              cfg_ok;
    logic              accept;
    logic              enter_settle;
    logic              enter_count;
    logic              leave_count;
    logic              advance;
    logic              finish;
    logic              reject;
    logic              ro_sel;
    logic              rise;
    logic [CNT_W-1:0]  cnt_next;
    logic              sat_next;
    logic [GATE_W-1:0] gate_load;

    assign cfg_ok    = (bus.first_idx <= bus.last_idx) && ({1'b0, bus.last_idx} < NUM_RO_W);
    assign ro_sel    = ro_in[cur_idx];
    assign rise      = sync_q[1] & ~edge_hist;
    // A zero gate length still opens a one-cycle window.
    assign gate_load = (gate_q == '0) ? '0 : gate_q - GATE_W'(1);

    always_comb begin
        cnt_next = count;
        sat_next = sat;
        if (rise) begin
            if (count == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort overrides every other request, so all strobes stay low in that cycle.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        enter_settle = 1'b0;
        enter_count  = 1'b0;
        leave_count  = 1'b0;
        advance      = 1'b0;
        finish       = 1'b0;
        reject       = 1'b0;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (cfg_ok) begin
                            state_next   = SETTLE;
                            accept       = 1'b1;
                            enter_settle = 1'b1;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state_next  = COUNT;
                        enter_count = 1'b1;
                    end
                end
                COUNT: begin
                    if (gate_cnt == '0) begin
                        state_next  = REPORT;
                        leave_count = 1'b1;
                    end
                end
                REPORT: begin
                    if (bus.res_ready) begin
                        if (cur_idx == last_q) begin
                            state_next = IDLE;
                            finish     = 1'b1;
                        end else begin
                            state_next   = SETTLE;
                            advance      = 1'b1;
                            enter_settle = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_idx     <= '0;
            last_q      <= '0;
            gate_q      <= '0;
            settle_cnt  <= '0;
            gate_cnt    <= '0;
            sync_q      <= '0;
            edge_hist   <= 1'b0;
            count       <= '0;
            sat         <= 1'b0;
            res_idx_q   <= '0;
            res_count_q <= '0;
            res_sat_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= finish;
            err_q  <= reject;

            if (accept) begin
                cur_idx <= bus.first_idx;
                last_q  <= bus.last_idx;
                gate_q  <= bus.gate_cycles;
            end else if (advance) begin
                cur_idx <= cur_idx + IDX_W'(1);
            end

            // Fresh oscillator: forget whatever the previous one left in the synchronizer.
            if (enter_settle) begin
                sync_q     <= '0;
                edge_hist  <= 1'b0;
                settle_cnt <= SETTLE_LAST;
            end else if (state == SETTLE || state == COUNT) begin
                sync_q    <= {sync_q[0], ro_sel};
                edge_hist <= sync_q[1];
                if (state == SETTLE && settle_cnt != '0) begin
                    settle_cnt <= settle_cnt - SET_W'(1);
                end
            end

            if (enter_count) begin
                count    <= '0;
                sat      <= 1'b0;
                gate_cnt <= gate_load;
            end else if (state == COUNT) begin
                count <= cnt_next;
                sat   <= sat_next;
                if (gate_cnt != '0) begin
                    gate_cnt <= gate_cnt - GATE_W'(1);
                end
            end

            if (leave_count) begin
                res_idx_q   <= cur_idx;
                res_count_q <= cnt_next;
                res_sat_q   <= sat_next;
            end
        end
    end

    always_comb begin
        ro_en = '0;
        if (state == SETTLE || state == COUNT) begin
            ro_en = NUM_RO'(1) << cur_idx;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.res_valid = (state == REPORT);
    assign bus.res_idx   = res_idx_q;
    assign bus.res_count = res_count_q;
    assign bus.res_sat   = res_sat_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// Bench for ro_scan_ctrl: directed scenarios and randomized scans, with counts checked
// against an edge-rate model (rises in a window of G samples of a period-P square wave).
`timescale 1ns/1ps
module tb_ro_scan_ctrl;
    localparam int NUM_RO     = 100;
    localparam int IDX_W      = 7;
    localparam int GATE_W     = 16;
    localparam int CNT_W      = 24;
    localparam int SAT_CNT_W  = 4;
    localparam int SETTLE_CYC = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_RO-1:0] ro_in = '0;
    logic [NUM_RO-1:0] ro_en;
    logic [NUM_RO-1:0] ro_en4;
    int                ro_period [NUM_RO];
    int                ro_phase  [NUM_RO];
    int                vectors = 0;
    int                miscompares = 0;

    ro_scan_ctrl_if #(.IDX_W(IDX_W), .GATE_W(GATE_W), .CNT_W(CNT_W))     bus ();
    ro_scan_ctrl_if #(.IDX_W(IDX_W), .GATE_W(GATE_W), .CNT_W(SAT_CNT_W)) bus4 ();

    ro_scan_ctrl #(
        .NUM_RO(NUM_RO), .IDX_W(IDX_W), .GATE_W(GATE_W), .CNT_W(CNT_W), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en), .bus(bus)
    );

    ro_scan_ctrl #(
        .NUM_RO(NUM_RO), .IDX_W(IDX_W), .GATE_W(GATE_W), .CNT_W(SAT_CNT_W), .SETTLE_CYC(SETTLE_CYC)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .ro_in(ro_in), .ro_en(ro_en4), .bus(bus4)
    );

    always #5 clk = ~clk;

    // Oscillators change on the falling edge so every rising-edge sample is clean.
    always @(negedge clk) begin
        for (int i = 0; i < NUM_RO; i++) begin
            if (ro_period[i] < 2) begin
                ro_phase[i] = 0;
                ro_in[i]    = 1'b0;
            end else begin
                ro_phase[i] = (ro_phase[i] + 1) % ro_period[i];
                ro_in[i]    = (ro_phase[i] < ro_period[i] / 2);
            end
        end
    end

    function automatic logic [NUM_RO-1:0] onehot(input int idx);
        logic [NUM_RO-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        vectors++;
        assert ($onehot0(ro_en) && $onehot0(ro_en4)) else begin
            miscompares++;
            $error("[TB] FAIL ro_en_onehot: observed %h / %h, required at most one bit set", ro_en, ro_en4);
        end
    endtask

    task automatic check_output(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_result(input string tag, input logic [63:0] cnt, input logic sat_flag,
                                input int period, input int g, input int cnt_w);
        logic [63:0] lo;
        logic [63:0] hi;
        logic [63:0] max_v;
        max_v = (64'd1 << cnt_w) - 64'd1;
        if (period < 2) begin
            lo = 64'd0;
            hi = 64'd0;
        end else begin
            lo = 64'(g / period);
            hi = 64'((g + period - 1) / period);
        end
        if (lo > max_v) begin
            vectors++;
            assert (cnt === max_v && sat_flag === 1'b1) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed count %0d sat %b, expected count %0d sat 1", tag, cnt, sat_flag, max_v);
            end
        end else if (hi <= max_v) begin
            vectors++;
            assert (cnt >= lo && cnt <= hi && sat_flag === 1'b0) else begin
                miscompares++;
                $error("[TB] FAIL %s: observed count %0d sat %b, expected count %0d..%0d sat 0", tag, cnt, sat_flag, lo, hi);
            end
        end
    endtask

    task automatic start_main(input int first, input int last, input int gate);
        bus.first_idx   = IDX_W'(first);
        bus.last_idx    = IDX_W'(last);
        bus.gate_cycles = GATE_W'(gate);
        bus.start       = 1'b1;
        tick();
        bus.start       = 1'b0;
    endtask

    task automatic wait_valid_main(input int exp_lat, input string tag);
        int n;
        n = 0;
        while (bus.res_valid !== 1'b1 && n < exp_lat + 40) begin
            tick();
            bus.start = 1'b0;
            n++;
        end
        check_output({tag, "_latency"}, 128'(n), 128'(exp_lat));
    endtask

    task automatic run_scan(input int first, input int last, input int gate, input int stall);
        int               g;
        logic [IDX_W-1:0] held_idx;
        logic [CNT_W-1:0] held_count;
        logic             held_sat;
        g = (gate == 0) ? 1 : gate;
        start_main(first, last, gate);
        check_output("scan_busy", 128'(bus.busy), 128'(1));
        check_output("scan_en_first", 128'(ro_en), 128'(onehot(first)));
        // A second start with garbage config mid-scan must change nothing.
        bus.start       = 1'b1;
        bus.first_idx   = IDX_W'($urandom);
        bus.last_idx    = IDX_W'($urandom);
        bus.gate_cycles = GATE_W'($urandom);
        for (int idx = first; idx <= last; idx++) begin
            wait_valid_main(SETTLE_CYC + g, "scan");
            check_output("res_idx", 128'(bus.res_idx), 128'(idx));
            check_result("res_count", 64'(bus.res_count), bus.res_sat, ro_period[idx], g, CNT_W);
            check_output("report_en_off", 128'(ro_en), 128'(0));
            held_idx   = bus.res_idx;
            held_count = bus.res_count;
            held_sat   = bus.res_sat;
            for (int s = 0; s < stall; s++) begin
                tick();
                check_output("stall_hold", 128'({bus.res_valid, bus.res_idx, bus.res_count, bus.res_sat}),
                             128'({1'b1, held_idx, held_count, held_sat}));
                check_output("stall_en_off", 128'(ro_en), 128'(0));
            end
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
            if (idx < last) begin
                check_output("next_settle", 128'({bus.busy, bus.res_valid, bus.done}), 128'(3'b100));
                check_output("next_en", 128'(ro_en), 128'(onehot(idx + 1)));
            end else begin
                check_output("scan_done", 128'({bus.busy, bus.res_valid, bus.done}), 128'(3'b001));
                tick();
                check_output("done_single", 128'(bus.done), 128'(0));
            end
        end
    endtask

    task automatic sat_scan(input int idx, input int period, input int gate);
        int n;
        int g;
        g = (gate == 0) ? 1 : gate;
        n = 0;
        ro_period[idx]   = period;
        bus4.first_idx   = IDX_W'(idx);
        bus4.last_idx    = IDX_W'(idx);
        bus4.gate_cycles = GATE_W'(gate);
        bus4.start       = 1'b1;
        tick();
        bus4.start       = 1'b0;
        while (bus4.res_valid !== 1'b1 && n < SETTLE_CYC + g + 40) begin
            tick();
            n++;
        end
        check_output("sat_latency", 128'(n), 128'(SETTLE_CYC + g));
        check_output("sat_idx", 128'(bus4.res_idx), 128'(idx));
        check_result("sat_count", 64'(bus4.res_count), bus4.res_sat, period, g, SAT_CNT_W);
        bus4.res_ready = 1'b1;
        tick();
        bus4.res_ready = 1'b0;
        check_output("sat_done", 128'({bus4.busy, bus4.done}), 128'(2'b01));
    endtask

    initial begin
        int   first;
        int   last;
        int   gate;
        int   stall;
        logic seen;

        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.first_idx    = '0;
        bus.last_idx     = '0;
        bus.gate_cycles  = '0;
        bus.res_ready    = 1'b0;
        bus4.start       = 1'b0;
        bus4.abort       = 1'b0;
        bus4.first_idx   = '0;
        bus4.last_idx    = '0;
        bus4.gate_cycles = '0;
        bus4.res_ready   = 1'b0;
        repeat (3) tick();
        check_output("reset_outputs", 128'({bus.busy, bus.res_valid, bus.done, bus.err, bus.res_sat,
                                            bus.res_idx, bus.res_count}), 128'(0));
        check_output("reset_en", 128'(ro_en), 128'(0));
        rst_n = 1'b1;
        tick();

        for (int i = 3; i <= 5; i++) ro_period[i] = 10;
        run_scan(3, 5, 100, 0);

        ro_period[10] = 7;
        ro_period[11] = 3;
        run_scan(10, 11, 30, 20);

        start_main(7, 2, 10);
        check_output("err_order", 128'({bus.err, bus.busy}), 128'(2'b10));
        tick();
        check_output("err_order_end", 128'({bus.err, bus.busy}), 128'(0));
        start_main(0, 100, 10);
        check_output("err_range", 128'({bus.err, bus.busy}), 128'(2'b10));
        tick();
        check_output("err_range_end", 128'({bus.err, bus.busy}), 128'(0));

        ro_period[99] = 2;
        run_scan(99, 99, 0, 0);

        bus.abort = 1'b1;
        start_main(0, 1, 5);
        bus.abort = 1'b0;
        check_output("abort_beats_start", 128'({bus.busy, bus.err}), 128'(0));

        ro_period[3] = 5;
        ro_period[4] = 5;
        start_main(3, 6, 50);
        wait_valid_main(SETTLE_CYC + 50, "abort_first");
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        repeat (SETTLE_CYC + 10) tick();
        check_output("abort_pre_en", 128'(ro_en), 128'(onehot(4)));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_output("abort_state", 128'({bus.busy, bus.res_valid, bus.done}), 128'(0));
        check_output("abort_en", 128'(ro_en), 128'(0));
        seen = 1'b0;
        repeat (80) begin
            tick();
            seen = seen | bus.res_valid | bus.done | bus.busy;
        end
        check_output("abort_quiet", 128'(seen), 128'(0));

        ro_period[20] = 6;
        ro_period[21] = 6;
        start_main(20, 21, 10);
        wait_valid_main(SETTLE_CYC + 10, "reset_report");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_output("reset_mid_outputs", 128'({bus.busy, bus.res_valid, bus.done, bus.err, bus.res_sat,
                                                bus.res_idx, bus.res_count}), 128'(0));
        check_output("reset_mid_en", 128'(ro_en), 128'(0));
        tick();
        run_scan(20, 20, 12, 0);

        sat_scan(5, 4, 100);
        sat_scan(6, 12, 100);
        sat_scan(7, 4, 60);
        sat_scan(8, 4, 64);

        repeat (6) begin
            first = int'($urandom_range(0, NUM_RO - 4));
            last  = first + int'($urandom_range(0, 3));
            gate  = int'($urandom_range(0, 60));
            stall = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
            for (int i = first; i <= last; i++) begin
                ro_period[i] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 13));
            end
            run_scan(first, last, gate, stall);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ro_scan_ctrl.md
RO_SCAN_CTRL -- requirements
Module: ro_scan_ctrl

Interface
REQ-001 Parameter NUM_RO, default 100: number of ring oscillators under control.
REQ-002 Parameter IDX_W, default 7: index width, with 2^IDX_W >= NUM_RO.
REQ-003 Parameter GATE_W, default 16: gate-length width.
REQ-004 Parameter CNT_W, default 24: edge-counter width.
REQ-005 Parameter SETTLE_CYC, default 4: settle cycles before counting.
REQ-006 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-007 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-008 Port start, input, 1: one-cycle request to begin a scan; sampled only in IDLE.
REQ-009 Port abort, input, 1: terminates any scan.
REQ-010 Port first_idx, input, IDX_W: first oscillator to measure.
REQ-011 Port last_idx, input, IDX_W: last oscillator to measure (inclusive).
REQ-012 Port gate_cycles, input, GATE_W: count window length in clk cycles.
REQ-013 Port ro_in, input, NUM_RO: asynchronous oscillator outputs.
REQ-014 Port ro_en, output, NUM_RO: one-hot-or-zero oscillator enables.
REQ-015 Port busy, output, 1: high from scan acceptance until done or abort.
REQ-016 Port res_valid, output, 1: a result is available.
REQ-017 Port res_ready, input, 1: consumer accepts the result.
REQ-018 Port res_idx, output, IDX_W: index of the measured oscillator.
REQ-019 Port res_count, output, CNT_W: rising-edge count for that oscillator.
REQ-020 Port res_sat, output, 1: res_count saturated.
REQ-021 Port done, output, 1: one-cycle pulse on scan completion.
REQ-022 Port err, output, 1: one-cycle pulse when start is rejected.

Function
REQ-023 FSM states SHALL be IDLE, SETTLE, COUNT, REPORT; all state and datapath registers update only on clk.
REQ-024 start in IDLE with first_idx<=last_idx<NUM_RO SHALL latch all config inputs, set cur_idx=first_idx, and enter SETTLE next cycle with busy=1.
REQ-025 start in IDLE with first_idx>last_idx or last_idx>=NUM_RO SHALL pulse err for one cycle, stay in IDLE, and keep busy=0.
REQ-026 start outside IDLE SHALL be ignored; config inputs SHALL NOT be re-sampled mid-scan.
REQ-027 ro_en[cur_idx] SHALL be 1 only in SETTLE and COUNT; all other ro_en bits, and all bits in IDLE and REPORT, SHALL be 0.
REQ-028 ro_in[cur_idx] SHALL pass through a 2-flop synchronizer followed by a rising-edge detector.
REQ-029 The synchronizer and edge history SHALL be cleared on SETTLE entry.
REQ-030 SETTLE SHALL last exactly SETTLE_CYC cycles, then enter COUNT with the counter cleared.
REQ-031 COUNT SHALL last exactly max(gate_cycles,1) cycles, adding 1 per detected edge.
REQ-032 The counter SHALL saturate at 2^CNT_W-1 and set a sticky saturation flag for the current oscillator.
REQ-033 On leaving COUNT the block SHALL enter REPORT with res_valid=1 and res_idx=cur_idx, res_count and res_sat captured.
REQ-034 res_idx, res_count and res_sat SHALL be held stable while res_valid && !res_ready.
REQ-035 On a REPORT cycle with res_ready=1 and cur_idx<last_idx, the block SHALL drop res_valid, increment cur_idx, and enter SETTLE next cycle.
REQ-036 On a REPORT cycle with res_ready=1 and cur_idx==last_idx, the block SHALL drop res_valid, pulse done, drop busy, and enter IDLE next cycle.
REQ-037 abort in any state SHALL force IDLE next cycle with ro_en=0, res_valid=0 and busy=0, and no done pulse; abort takes priority over start, res_ready and counting.
REQ-038 Only oscillator frequencies below clk/2 SHALL be measured exactly; higher frequencies alias, which is accepted behaviour.
REQ-039 Per-oscillator latency from SETTLE entry to res_valid SHALL be SETTLE_CYC+max(gate_cycles,1) cycles.

Reset
REQ-040 With rst_n=0 at a clk edge, the block SHALL enter IDLE.
REQ-041 Reset SHALL drive ro_en=0, busy=0, res_valid=0, res_idx=0, res_count=0, res_sat=0, done=0 and err=0.
REQ-042 Reset SHALL clear the synchronizer, counter and cur_idx.
REQ-043 Reset mid-scan SHALL behave like abort and discard any pending result.

Verification
REQ-044 Scan: first=3, last=5, gate=100, ro_in[3..5] at clk/10 with res_ready=1 -> three results, idx 3,4,5, count 10 ±1 each; done 1 cycle after the third handshake.
REQ-045 Backpressure: res_ready=0 for 20 cycles in REPORT -> res_* stable, ro_en=0, no SETTLE until res_ready=1.
REQ-046 Saturation: CNT_W=4, gate=100, ro_in at clk/4 -> res_count=15, res_sat=1.
REQ-047 Config errors: first=7, last=2 -> err pulse, busy stays 0; last=100 -> err pulse; gate=0 -> COUNT lasts 1 cycle.
REQ-048 Abort: abort asserted mid-COUNT of idx 4 -> next cycle IDLE, ro_en=0, no res_valid, no done.
REQ-049 Reset: rst_n low during REPORT -> next cycle all outputs at reset values; a new start is accepted afterwards.
REQ-050 Enables: ro_en has at most one bit set in every cycle of every test.
